// File: rtl/step_phase_decoder.sv
// step_phase_decoder: recovers step events, direction, position and revolution count from a stepper coil pattern
module step_phase_decoder #(
  parameter int STEPS_PER_REV = 400,
  parameter int POS_W = 16,
  parameter int FILTER = 4,
  parameter int IDLE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       phase_in,
  input  logic             clr,
  input  logic             err_clr,
  output logic             step_valid,
  output logic             step_dir,
  output logic [POS_W-1:0] position,
  output logic [8:0]       angle_idx,
  output logic [7:0]       rev_cnt,
  output logic             mode,
  output logic             moving,
  output logic             err_illegal,
  output logic             err_skip
);
  localparam int CW = $clog2(FILTER + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [8:0] LAST = 9'(STEPS_PER_REV - 1);
  typedef enum logic {NOREF, REF} ref_t;
  ref_t ref_st;
  logic [3:0] s1, s2, cand, acc;
  logic [CW-1:0] cnt;
  logic [1:0] ref_idx, nidx, delta;
  logic [IW-1:0] idle;
  logic acc_ev, is1, is2, valid, same_mode, fwd, rev, skip, ill;
  // Decode the filtered candidate against the stored reference
  always_comb begin
    is1 = cand inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
    is2 = cand inside {4'b0011, 4'b0110, 4'b1100, 4'b1001};
    valid = is1 | is2;
    nidx = (cand == 4'b0010 || cand == 4'b0110) ? 2'd1 :
           (cand == 4'b0100 || cand == 4'b1100) ? 2'd2 :
           (cand == 4'b1000 || cand == 4'b1001) ? 2'd3 : 2'd0;
    delta = nidx - ref_idx;
    acc_ev = cnt == CW'(FILTER) && cand != acc;
    same_mode = ref_st == REF && is2 == mode;
    fwd = acc_ev && valid && same_mode && delta == 2'd1;
    rev = acc_ev && valid && same_mode && delta == 2'd3;
    skip = acc_ev && valid && same_mode && delta == 2'd2;
    ill = acc_ev && (valid ? ref_st == REF && is2 != mode : cand != 4'b0000);
  end
  // Two-stage synchronizer followed by a stability counter on the candidate pattern
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      cand <= '0;
      cnt <= '0;
    end else begin
      s1 <= phase_in;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt <= CW'(1);
      end else if (cnt != CW'(FILTER)) cnt <= cnt + CW'(1);
    end
  end
  // Reference FSM: every accepted energized pattern becomes the new reference, 0000 or illegal drops it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_st <= NOREF;
      acc <= '0;
      ref_idx <= '0;
      mode <= 1'b0;
    end else if (acc_ev) begin
      acc <= cand;
      ref_st <= valid ? REF : NOREF;
      if (valid) begin
        ref_idx <= nidx;
        mode <= is2;
      end
    end
  end
  // Step pulse, counters with clear priority, sticky errors and idle timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_valid <= 1'b0;
      step_dir <= 1'b0;
      position <= '0;
      angle_idx <= '0;
      rev_cnt <= '0;
      moving <= 1'b0;
      idle <= '0;
      err_illegal <= 1'b0;
      err_skip <= 1'b0;
    end else begin
      step_valid <= fwd | rev;
      if (fwd | rev) step_dir <= fwd;
      position <= clr ? '0 : fwd ? position + POS_W'(1) : rev ? position - POS_W'(1) : position;
      angle_idx <= clr ? '0 : fwd ? (angle_idx == LAST ? 9'd0 : angle_idx + 9'd1) :
                   rev ? (angle_idx == 9'd0 ? LAST : angle_idx - 9'd1) : angle_idx;
      rev_cnt <= clr ? '0 : (fwd && angle_idx == LAST) ? rev_cnt + 8'd1 :
                 (rev && angle_idx == 9'd0) ? rev_cnt - 8'd1 : rev_cnt;
      err_illegal <= ill | (err_illegal & ~err_clr);
      err_skip <= skip | (err_skip & ~err_clr);
      if (fwd | rev) begin
        moving <= 1'b1;
        idle <= IW'(IDLE_CYCLES - 1);
      end else if (moving) begin
        if (idle == '0) moving <= 1'b0;
        else idle <= idle - IW'(1);
      end
    end
  end
endmodule
